// File: rtl/rst_seq_pkg.sv
// Shared definitions for the DCM reset/bring-up sequencer: state encoding and
// default count values, also usable by benches and other SoC glue.
package rst_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_DCM_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_HOLD      = 3'd2,
        S_REL_MEM   = 3'd3,
        S_REL_VDU   = 3'd4,
        S_REL_CPU   = 3'd5,
        S_RUN       = 3'd6
    } state_t;

    localparam int unsigned DEF_CNT_W        = 12;
    localparam int unsigned DEF_DCM_RST_LEN  = 4;
    localparam int unsigned DEF_LOCK_STABLE  = 127;
    localparam int unsigned DEF_LOCK_TIMEOUT = 4095;
    localparam int unsigned DEF_STAGE_GAP    = 16;

endpackage

// File: rtl/rst_sequencer_if.sv
// Control/status bundle between the reset sequencer and the clock block / SoC glue.
interface rst_sequencer_if;
    import rst_seq_pkg::*;

    logic               locked_i;
    logic               soft_rst_i;
    logic               dcm_rst_o;
    logic               rst_mem_o;
    logic               rst_vdu_o;
    logic               rst_cpu_o;
    logic               ready_o;
    logic               lock_fail_o;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  locked_i, soft_rst_i,
        output dcm_rst_o, rst_mem_o, rst_vdu_o, rst_cpu_o, ready_o, lock_fail_o, state_o
    );

    modport slave (
        output locked_i, soft_rst_i,
        input  dcm_rst_o, rst_mem_o, rst_vdu_o, rst_cpu_o, ready_o, lock_fail_o, state_o
    );

endinterface

// File: rtl/rst_timer.sv
// Loadable saturating down-counter; done_c flags a zero count.
module rst_timer #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done_c
);

    logic [W-1:0] cnt;

    // Load has priority; the count stops at zero rather than wrapping.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/rst_sequencer.sv
// DCM bring-up and staged domain-reset release (memory, VDU, CPU), with lock
// qualification, timeout retry, lock-loss and software-reset re-sequencing.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned DCM_RST_LEN  = DEF_DCM_RST_LEN,
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned STAGE_GAP    = DEF_STAGE_GAP
) (
    input  logic              clk,
    input  logic              rst,
    rst_sequencer_if.master   bus
);

    state_t             state;
    state_t             nxt;
    logic               restart;
    logic               timeout_hit;
    logic               stage_load;
    logic [CNT_W-1:0]   stage_val;
    logic               stage_en;
    logic               stage_done;
    logic               to_load;
    logic               to_done;
    logic               dcm_rst_d;
    logic               rst_mem_d;
    logic               rst_vdu_d;
    logic               rst_cpu_d;
    logic               ready_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_DCM_RST;
        end else begin
            state <= nxt;
        end
    end

    // Next state; restart reloads the stage counter without a state change.
    always_comb begin
        nxt         = state;
        restart     = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            S_DCM_RST: begin
                if (stage_done) nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (bus.locked_i && stage_done) begin
                    nxt = S_REL_MEM;
                end else if (to_done) begin
                    nxt         = S_DCM_RST;
                    timeout_hit = 1'b1;
                end else if (!bus.locked_i) begin
                    restart = 1'b1;
                end
            end
            S_HOLD: begin
                if (!bus.locked_i)       nxt = S_WAIT_LOCK;
                else if (bus.soft_rst_i) restart = 1'b1;
                else if (stage_done)     nxt = S_REL_MEM;
            end
            S_REL_MEM: begin
                if (!bus.locked_i)       nxt = S_WAIT_LOCK;
                else if (bus.soft_rst_i) nxt = S_HOLD;
                else if (stage_done)     nxt = S_REL_VDU;
            end
            S_REL_VDU: begin
                if (!bus.locked_i)       nxt = S_WAIT_LOCK;
                else if (bus.soft_rst_i) nxt = S_HOLD;
                else if (stage_done)     nxt = S_REL_CPU;
            end
            S_REL_CPU: begin
                if (!bus.locked_i)       nxt = S_WAIT_LOCK;
                else if (bus.soft_rst_i) nxt = S_HOLD;
                else if (stage_done)     nxt = S_RUN;
            end
            S_RUN: begin
                if (!bus.locked_i)       nxt = S_WAIT_LOCK;
                else if (bus.soft_rst_i) nxt = S_HOLD;
            end
            default: nxt = S_DCM_RST;
        endcase
    end

    // Counter control: the entered state's length is loaded as N-1 so a state lasts N cycles.
    always_comb begin
        stage_load = rst || (nxt != state) || restart;
        stage_en   = (state == S_WAIT_LOCK) ? bus.locked_i : 1'b1;
        to_load    = rst || ((nxt == S_WAIT_LOCK) && (state != S_WAIT_LOCK));
        stage_val  = CNT_W'(STAGE_GAP - 1);
        if (rst || (nxt == S_DCM_RST)) begin
            stage_val = CNT_W'(DCM_RST_LEN - 1);
        end else if (nxt == S_WAIT_LOCK) begin
            stage_val = CNT_W'(LOCK_STABLE - 1);
        end
    end

    rst_timer #(.W(CNT_W)) u_stage_timer (
        .clk      (clk),
        .load     (stage_load),
        .load_val (stage_val),
        .en       (stage_en),
        .done_c   (stage_done)
    );

    rst_timer #(.W(CNT_W)) u_timeout_timer (
        .clk      (clk),
        .load     (to_load),
        .load_val (CNT_W'(LOCK_TIMEOUT - 1)),
        .en       (1'b1),
        .done_c   (to_done)
    );

    // Output decode from the next state.
    always_comb begin
        dcm_rst_d = 1'b0;
        rst_mem_d = 1'b1;
        rst_vdu_d = 1'b1;
        rst_cpu_d = 1'b1;
        ready_d   = 1'b0;
        unique case (nxt)
            S_DCM_RST: dcm_rst_d = 1'b1;
            S_REL_MEM: rst_mem_d = 1'b0;
            S_REL_VDU: begin
                rst_mem_d = 1'b0;
                rst_vdu_d = 1'b0;
            end
            S_REL_CPU: begin
                rst_mem_d = 1'b0;
                rst_vdu_d = 1'b0;
                rst_cpu_d = 1'b0;
            end
            S_RUN: begin
                rst_mem_d = 1'b0;
                rst_vdu_d = 1'b0;
                rst_cpu_d = 1'b0;
                ready_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs; lock_fail_o is sticky until rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dcm_rst_o   <= 1'b1;
            bus.rst_mem_o   <= 1'b1;
            bus.rst_vdu_o   <= 1'b1;
            bus.rst_cpu_o   <= 1'b1;
            bus.ready_o     <= 1'b0;
            bus.lock_fail_o <= 1'b0;
            bus.state_o     <= STATE_W'(S_DCM_RST);
        end else begin
            bus.dcm_rst_o   <= dcm_rst_d;
            bus.rst_mem_o   <= rst_mem_d;
            bus.rst_vdu_o   <= rst_vdu_d;
            bus.rst_cpu_o   <= rst_cpu_d;
            bus.ready_o     <= ready_d;
            bus.lock_fail_o <= bus.lock_fail_o | timeout_hit;
            bus.state_o     <= STATE_W'(nxt);
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with short counts; compares the full output
// vector {state, dcm, mem, vdu, cpu, ready, lock_fail} at hand-computed cycles.
module tb_rst_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rst_sequencer_if u_if ();

    rst_sequencer #(
        .CNT_W        (12),
        .DCM_RST_LEN  (3),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (32),
        .STAGE_GAP    (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int snap();
        return int'({u_if.state_o, u_if.dcm_rst_o, u_if.rst_mem_o, u_if.rst_vdu_o,
                     u_if.rst_cpu_o, u_if.ready_o, u_if.lock_fail_o});
    endfunction

    function automatic int pk(input int st, input bit d, input bit m, input bit v,
                              input bit c, input bit r, input bit f);
        return int'({3'(st), d, m, v, c, r, f});
    endfunction

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        u_if.locked_i   = 1'b1;
        u_if.soft_rst_i = 1'b0;

        // Reset state, then clean bring-up.
        tick(2);
        check("reset", snap(), pk(0, 1, 1, 1, 1, 0, 0));
        rst = 1'b0;
        tick(2);
        check("t1_dcm_2nd", snap(), pk(0, 1, 1, 1, 1, 0, 0));
        tick(1);
        check("t1_wait_entry", snap(), pk(1, 0, 1, 1, 1, 0, 0));
        tick(7);
        check("t1_wait_7", snap(), pk(1, 0, 1, 1, 1, 0, 0));
        tick(1);
        check("t1_rel_mem", snap(), pk(3, 0, 0, 1, 1, 0, 0));
        tick(3);
        check("t1_mem_hold", snap(), pk(3, 0, 0, 1, 1, 0, 0));
        tick(1);
        check("t1_rel_vdu", snap(), pk(4, 0, 0, 0, 1, 0, 0));
        tick(4);
        check("t1_rel_cpu", snap(), pk(5, 0, 0, 0, 0, 0, 0));
        tick(3);
        check("t1_cpu_hold", snap(), pk(5, 0, 0, 0, 0, 0, 0));
        tick(1);
        check("t1_run", snap(), pk(6, 0, 0, 0, 0, 1, 0));

        // Lock loss in RUN: requalify without a DCM pulse.
        u_if.locked_i = 1'b0;
        tick(1);
        check("t4_loss", snap(), pk(1, 0, 1, 1, 1, 0, 0));
        u_if.locked_i = 1'b1;
        tick(7);
        check("t4_requal_7", snap(), pk(1, 0, 1, 1, 1, 0, 0));
        tick(1);
        check("t4_rel_mem", snap(), pk(3, 0, 0, 1, 1, 0, 0));
        tick(12);
        check("t4_run", snap(), pk(6, 0, 0, 0, 0, 1, 0));

        // Soft reset pulse in RUN.
        u_if.soft_rst_i = 1'b1;
        tick(1);
        check("t5_hold", snap(), pk(2, 0, 1, 1, 1, 0, 0));
        u_if.soft_rst_i = 1'b0;
        tick(3);
        check("t5_hold_3", snap(), pk(2, 0, 1, 1, 1, 0, 0));
        tick(1);
        check("t5_rel_mem", snap(), pk(3, 0, 0, 1, 1, 0, 0));
        tick(4);
        check("t5_rel_vdu", snap(), pk(4, 0, 0, 0, 1, 0, 0));
        tick(4);
        check("t5_rel_cpu", snap(), pk(5, 0, 0, 0, 0, 0, 0));
        tick(4);
        check("t5_run", snap(), pk(6, 0, 0, 0, 0, 1, 0));

        // Soft reset held 3 cycles restarts the HOLD count.
        u_if.soft_rst_i = 1'b1;
        tick(3);
        u_if.soft_rst_i = 1'b0;
        tick(3);
        check("t5_held_hold", snap(), pk(2, 0, 1, 1, 1, 0, 0));
        tick(1);
        check("t5_held_rel", snap(), pk(3, 0, 0, 1, 1, 0, 0));
        tick(12);
        check("t5_held_run", snap(), pk(6, 0, 0, 0, 0, 1, 0));

        // Soft reset together with lock loss: lock loss wins.
        u_if.soft_rst_i = 1'b1;
        u_if.locked_i   = 1'b0;
        tick(1);
        check("t5b_loss_wins", snap(), pk(1, 0, 1, 1, 1, 0, 0));
        u_if.soft_rst_i = 1'b0;
        u_if.locked_i   = 1'b1;
        tick(8);
        check("t5b_rel_mem", snap(), pk(3, 0, 0, 1, 1, 0, 0));

        // Lock glitch during qualification.
        rst = 1'b1;
        tick(1);
        check("t2_reset", snap(), pk(0, 1, 1, 1, 1, 0, 0));
        rst = 1'b0;
        u_if.locked_i = 1'b0;
        tick(3);
        check("t2_wait_entry", snap(), pk(1, 0, 1, 1, 1, 0, 0));
        u_if.locked_i = 1'b1;
        tick(5);
        u_if.locked_i = 1'b0;
        tick(1);
        u_if.locked_i = 1'b1;
        tick(7);
        check("t2_requal_7", snap(), pk(1, 0, 1, 1, 1, 0, 0));
        tick(1);
        check("t2_rel_mem", snap(), pk(3, 0, 0, 1, 1, 0, 0));

        // No lock: timeout, retry every 35 cycles, sticky lock_fail_o.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        u_if.locked_i = 1'b0;
        tick(3);
        check("t3_wait_entry", snap(), pk(1, 0, 1, 1, 1, 0, 0));
        tick(31);
        check("t3_before_to", snap(), pk(1, 0, 1, 1, 1, 0, 0));
        tick(1);
        check("t3_timeout", snap(), pk(0, 1, 1, 1, 1, 0, 1));
        tick(2);
        check("t3_dcm_3rd", snap(), pk(0, 1, 1, 1, 1, 0, 1));
        tick(1);
        check("t3_rewait", snap(), pk(1, 0, 1, 1, 1, 0, 1));
        tick(31);
        check("t3_before_to2", snap(), pk(1, 0, 1, 1, 1, 0, 1));
        tick(1);
        check("t3_timeout2", snap(), pk(0, 1, 1, 1, 1, 0, 1));

        // Recover lock, reach REL_VDU, then rst.
        u_if.locked_i = 1'b1;
        tick(3);
        check("t6_wait", snap(), pk(1, 0, 1, 1, 1, 0, 1));
        tick(8);
        check("t6_rel_mem", snap(), pk(3, 0, 0, 1, 1, 0, 1));
        tick(4);
        check("t6_rel_vdu", snap(), pk(4, 0, 0, 0, 1, 0, 1));
        rst = 1'b1;
        tick(1);
        check("t6_rst", snap(), pk(0, 1, 1, 1, 1, 0, 0));
        rst = 1'b0;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
